// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed 4-digit 7-segment display driver.
// Scans four digit slots with a prescaler. Incoming digit words are staged
// in a pending buffer and promoted to the displayed word only on a frame
// edge. Optional leading-zero suppression and per-slot anode dead time are
// applied. Anodes and segments are active low.
module disp_scan_ctrl #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_digits,
  input  logic        blank_lz,
  output logic [1:0]  sel,
  output logic [3:0]  digit,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;
  logic          frame_edge;

  logic [15:0]   active;
  logic [15:0]   pend;
  logic          pend_vld;
  logic          pend_vld_nxt;
  logic          accept;
  logic          apply;

  logic          blank_slot;
  logic          dead;

  // Segment patterns {g,f,e,d,c,b,a}, active low; A-F use the usual A,b,C,d,E,F glyphs.
  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick       = (cnt == CW'(DIV - 1));
  assign frame_edge = tick && (sel == 2'd3);

  // Prescaler and slot select; sel wraps 3->0 in its 2 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sel <= '0;
    end else if (tick) begin
      cnt <= '0;
      sel <= sel + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Handshake and frame-edge promotion. upd_ready is only ever 1 while the
  // pending buffer is empty, so an accept and a promotion never coincide.
  always_comb begin
    accept       = upd_valid & upd_ready;
    apply        = frame_edge & pend_vld;
    pend_vld_nxt = pend_vld;
    if (apply) begin
      pend_vld_nxt = 1'b0;
    end else if (accept) begin
      pend_vld_nxt = 1'b1;
    end
  end

  // Double buffer: pending word captured on accept, made active on a frame edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pend_vld  <= 1'b0;
      upd_ready <= 1'b0;
      active    <= '0;
    end else begin
      if (accept) begin
        pend <= upd_digits;
      end
      if (apply) begin
        active <= pend;
      end
      pend_vld  <= pend_vld_nxt;
      upd_ready <= ~pend_vld_nxt;
    end
  end

  // Nibble for the current slot and leading-zero suppression decision.
  always_comb begin
    digit      = '0;
    blank_slot = 1'b0;
    unique case (sel)
      2'd0: digit = active[3:0];
      2'd1: digit = active[7:4];
      2'd2: digit = active[11:8];
      default: digit = active[15:12];
    endcase
    if (blank_lz) begin
      unique case (sel)
        2'd3:    blank_slot = (active[15:12] == 4'h0);
        2'd2:    blank_slot = (active[15:8]  == 8'h00);
        2'd1:    blank_slot = (active[15:4]  == 12'h000);
        default: blank_slot = 1'b0;
      endcase
    end
  end

  // The anode register loads the new slot in the cycle where cnt==0, so
  // gating while cnt < BLANK_CYC yields exactly BLANK_CYC dark cycles per slot.
  always_comb begin
    dead = (BLANK_CYC > 0) && (int'(cnt) < BLANK_CYC);
  end

  // Registered display outputs, one cycle behind sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= '1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      seg_n      <= blank_slot ? 7'h7F : seg_dec(digit);
      an_n       <= dead ? 4'hF : ~(4'b0001 << sel);
      frame_done <= frame_edge;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl (DIV=4). Main instance uses BLANK_CYC=1, a second
// instance uses BLANK_CYC=0. Displayed frames are collected from the pins and
// compared against hand-computed segment words queued by the stimulus.
module tb_disp_scan_ctrl;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78;
  localparam logic [6:0] S8 = 7'h00, S9 = 7'h10, SA = 7'h08, SB = 7'h03;
  localparam logic [6:0] SC = 7'h46, SD = 7'h21, SE = 7'h06, SF = 7'h0E;
  localparam logic [6:0] SX = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_digits;
  logic        blank_lz;
  logic [1:0]  sel;
  logic [3:0]  digit;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  logic        z_valid = 1'b0;
  logic [15:0] z_digits = '0;
  logic        z_ready;
  logic [1:0]  z_sel;
  logic [3:0]  z_digit;
  logic [6:0]  z_seg;
  logic [3:0]  z_an;
  logic        z_fd;

  int n_chk  = 0;
  int n_fail = 0;
  int acc_cnt = 0;

  logic [27:0] sb_q[$];
  logic [16:0] tx_q[$];

  disp_scan_ctrl #(.DIV(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_digits(upd_digits), .blank_lz(blank_lz), .sel(sel), .digit(digit),
    .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
  );

  disp_scan_ctrl #(.DIV(4), .BLANK_CYC(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .upd_valid(z_valid), .upd_ready(z_ready),
    .upd_digits(z_digits), .blank_lz(blank_lz), .sel(z_sel), .digit(z_digit),
    .seg_n(z_seg), .an_n(z_an), .frame_done(z_fd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] fr(input logic [6:0] s3, input logic [6:0] s2,
                                     input logic [6:0] s1, input logic [6:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  task automatic wait_frame();
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!frame_done && t < 40);
    check("frame_done_seen", {31'b0, frame_done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an_n"},  {28'b0, an_n},      32'hF);
    check({tag, "_seg_n"}, {25'b0, seg_n},     32'h7F);
    check({tag, "_sel"},   {30'b0, sel},       32'h0);
    check({tag, "_ready"}, {31'b0, upd_ready}, 32'h0);
    check({tag, "_digit"}, {28'b0, digit},     32'h0);
    check({tag, "_fdone"}, {31'b0, frame_done}, 32'h0);
  endtask

  // Monitor: gather one segment word per lit slot; a full frame is scored when slot 3 lights.
  initial begin : monitor
    logic [27:0] got;
    logic [3:0]  mask;
    logic [3:0]  prev;
    int          idx;
    got  = '0;
    mask = '0;
    prev = 4'hF;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mask = '0;
        prev = 4'hF;
      end else begin
        if (an_n != 4'hF && an_n != prev) begin
          case (an_n)
            4'hE:    idx = 0;
            4'hD:    idx = 1;
            4'hB:    idx = 2;
            4'h7:    idx = 3;
            default: idx = -1;
          endcase
          if (idx < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL anode_onehot: got %0h expected one-hot low at %0t", an_n, $time);
          end else begin
            got[idx*7 +: 7] = seg_n;
            mask[idx] = 1'b1;
            if (idx == 3) begin
              if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL frame_unexpected: got %0h expected none at %0t", got, $time);
              end else if (mask == 4'hF) begin
                check("frame", {4'b0, got}, {4'b0, sb_q.pop_front()});
              end
              mask = '0;
            end
          end
        end
        prev = an_n;
      end
    end
  end

  // Source driver: holds each word until upd_ready, bit 16 marks words expected
  // to be taken in the cycle right after a frame edge.
  initial begin : driver
    logic [16:0] cur;
    cur        = '0;
    upd_valid  = 1'b0;
    upd_digits = '0;
    forever begin
      @(negedge clk);
      if (!upd_valid && tx_q.size() > 0) begin
        cur        = tx_q.pop_front();
        upd_valid  = 1'b1;
        upd_digits = cur[15:0];
      end
      if (upd_valid && upd_ready && rst_n) begin
        acc_cnt++;
        if (cur[16]) check("accept_after_edge", {31'b0, frame_done}, 32'd1);
        @(posedge clk);
        #1;
        check("ready_drop", {31'b0, upd_ready}, 32'd0);
        upd_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] exp_an;
    logic [3:0] exp_zan;
    int         a0;
    int         t;
    blank_lz = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check_reset_outputs("rst_hold");
    check("rst_hold_nogap_an", {28'b0, z_an}, 32'hF);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", {31'b0, upd_ready}, 32'd0);
    sb_q.push_back(fr(S0, S0, S0, S0));

    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp_an  = ((k - 1) % 4 == 0) ? 4'hF : ~(4'b0001 << (((k - 1) / 4) % 4));
      exp_zan = ~(4'b0001 << (((k - 1) / 4) % 4));
      check("scan_sel",    {30'b0, sel},        (k / 4) % 4);
      check("scan_an",     {28'b0, an_n},       {28'b0, exp_an});
      check("scan_fdone",  {31'b0, frame_done}, (k % 16 == 0) ? 32'd1 : 32'd0);
      check("nogap_an",    {28'b0, z_an},       {28'b0, exp_zan});
      check("nogap_fdone", {31'b0, z_fd},       (k % 16 == 0) ? 32'd1 : 32'd0);
      if (k == 1) check("ready_after_edge", {31'b0, upd_ready}, 32'd1);
      if (k == 16) sb_q.push_back(fr(S0, S0, S0, S0));
      if (k == 18) begin
        tx_q.push_back({1'b0, 16'h1234});
        tx_q.push_back({1'b1, 16'h5678});
      end
    end

    wait_frame();
    sb_q.push_back(fr(S1, S2, S3, S4));
    wait_frame();
    sb_q.push_back(fr(S5, S6, S7, S8));
    blank_lz = 1'b1;
    tx_q.push_back({1'b0, 16'h0007});
    wait_frame();
    sb_q.push_back(fr(SX, SX, SX, S7));
    tx_q.push_back({1'b0, 16'h0000});
    wait_frame();
    sb_q.push_back(fr(SX, SX, SX, S0));
    tx_q.push_back({1'b0, 16'h0100});
    wait_frame();
    sb_q.push_back(fr(SX, S1, S0, S0));
    wait_frame();
    blank_lz = 1'b0;
    sb_q.push_back(fr(S0, S1, S0, S0));
    tx_q.push_back({1'b0, 16'hABCF});
    wait_frame();
    check("digit_slot0", {28'b0, digit}, 32'hF);
    sb_q.push_back(fr(SA, SB, SC, SF));
    tx_q.push_back({1'b0, 16'h9DE0});
    wait_frame();
    sb_q.push_back(fr(S9, SD, SE, S0));

    wait_frame();
    a0 = acc_cnt;
    tx_q.push_back({1'b0, 16'h4321});
    t = 0;
    while (acc_cnt == a0 && t < 10) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("pending_taken", acc_cnt, a0 + 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(fr(S0, S0, S0, S0));
    @(posedge clk);
    #1;
    check("ready_after_rerelease", {31'b0, upd_ready}, 32'd1);
    wait_frame();
    sb_q.push_back(fr(S0, S0, S0, S0));
    wait_frame();
    check("sb_drain", sb_q.size(), 32'd0);
    check("tx_drain", tx_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
